module_hazard_unit: RTL

Hazard and stall controller for the 5-stage RV32I pipeline; it is the control end of the pipeline-register interface. It decides, every cycle, which pipeline registers hold (stall) or clear (flush), and sets the EX-stage operand forwarding selects. A small FSM tracks multi-cycle data-memory waits. Saturating counters record stall and redirect cycles for performance analysis.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/module_sat_counter.sv | 14 +
 rtl/module_hazard_unit.sv | 65 ++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;
  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_e;
  localparam int REG_AW_DEF = 5;
endpackage

// File: rtl/module_sat_counter.sv
// module_sat_counter: saturating up-counter with sync clear and async reset
module module_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_o <= '0;
    else cnt_o <= clr_i ? '0 : (inc_i && !(&cnt_o)) ? cnt_o + 1'b1 : cnt_o;
endmodule

// File: rtl/module_hazard_unit.sv
// module_hazard_unit: stall/flush/forwarding control for the 5-stage RV32I pipeline
import hazard_pkg::*;
module module_hazard_unit #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic              load_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  input  logic              mispredict_e_i,
  input  logic              mem_req_m_i,
  input  logic              mem_ready_i,
  input  logic              clr_cnt_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              stall_m_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              flush_w_o,
  output logic              redirect_en_o,
  output logic [1:0]        fwd_a_e_o,
  output logic [1:0]        fwd_b_e_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  redir_cnt_o
);
  hz_state_e state;
  logic mem_stall, lw_stall, mis, lw;
  function automatic fwd_sel_e fwd(input logic [REG_AW-1:0] rs, rd_m, rd_w, input logic wm, ww);
    return (wm && rd_m != '0 && rd_m == rs) ? FWD_MEM : (ww && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
  endfunction
  assign mem_stall = mem_req_m_i & ~mem_ready_i;
  assign lw_stall  = load_e_i & (rd_e_i != '0) & (rd_e_i == rs1_d_i | rd_e_i == rs2_d_i);
  // a frozen EX keeps mispredict high, so it simply waits out the memory stall
  assign mis = ~rst_i & ~mem_stall & mispredict_e_i;
  assign lw  = ~rst_i & ~mem_stall & ~mispredict_e_i & lw_stall;
  assign stall_f_o     = (~rst_i & mem_stall) | lw;
  assign stall_d_o     = (~rst_i & mem_stall) | lw;
  assign stall_e_o     = ~rst_i & mem_stall;
  assign stall_m_o     = ~rst_i & mem_stall;
  assign flush_w_o     = ~rst_i & mem_stall;
  assign flush_d_o     = mis;
  assign flush_e_o     = mis | lw;
  assign redirect_en_o = mis;
  assign fwd_a_e_o = rst_i ? FWD_RF : fwd(rs1_e_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i);
  assign fwd_b_e_o = rst_i ? FWD_RF : fwd(rs2_e_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RUN;
    else state <= state == RUN ? (mem_stall ? MEM_WAIT : RUN) : (mem_ready_i | ~mem_req_m_i ? RUN : MEM_WAIT);
  module_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_cnt_i), .inc_i(stall_f_o), .cnt_o(stall_cnt_o)
  );
  module_sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_cnt_i), .inc_i(redirect_en_o), .cnt_o(redir_cnt_o)
  );
endmodule
